// File: rtl/mux4_arb_pkg.sv
// mux4_arb_pkg: shared state, channel types and the round-robin pick for mux4_rr_arbiter.
package mux4_arb_pkg;
    localparam int NUM_CH = 4;
    typedef enum logic [1:0] {IDLE, GRANT, GAP} state_e;
    typedef logic [1:0] ch_t;
    // Scans last+4 down to last+1 so the nearest requester after last wins.
    function automatic ch_t rr_pick(input logic [NUM_CH-1:0] req, input ch_t last);
        ch_t w;
        w = last;
        for (int i = NUM_CH; i >= 1; i--)
            if (req[last + ch_t'(i)]) w = last + ch_t'(i);
        return w;
    endfunction
endpackage

// File: rtl/mux4_dw.sv
// mux4_dw: 4:1 DW-bit mux with active-low enable; disabled output is zero.
module mux4_dw #(
    parameter int DW = 2
) (
    input  logic [DW-1:0] a_i,
    input  logic [DW-1:0] b_i,
    input  logic [DW-1:0] c_i,
    input  logic [DW-1:0] d_i,
    input  logic [1:0]    sel_i,
    input  logic          en_n_i,
    output logic [DW-1:0] y_o
);
    assign y_o = en_n_i ? '0 : sel_i[1] ? (sel_i[0] ? d_i : c_i) : (sel_i[0] ? b_i : a_i);
endmodule

// File: rtl/mux4_rr_arbiter.sv
// mux4_rr_arbiter: round-robin arbiter with burst cap driving a shared 4:1 mux.
// Define MUX4_ARB_GAP_EN to insert a one-cycle idle GAP after every grant.
module mux4_rr_arbiter
    import mux4_arb_pkg::*;
#(
    parameter int DW        = 2,
    parameter int BURST_LEN = 4
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic [3:0]    REQ,
    input  logic [DW-1:0] A,
    input  logic [DW-1:0] B,
    input  logic [DW-1:0] C,
    input  logic [DW-1:0] D,
    output logic [3:0]    GNT,
    output logic [1:0]    S,
    output logic          EN,
    output logic [DW-1:0] Y,
    output logic          VALID
);
    localparam int CW = $clog2(BURST_LEN + 1);
    state_e        state_q;
    logic [3:0]    gnt_q;
    ch_t           s_q;
    ch_t           last_q;
    logic          en_q;
    logic [CW-1:0] cnt_q;
    ch_t           win_d;
    logic          exit_d;
    // While granting, the current channel already counts as the last served one.
    assign win_d  = rr_pick(REQ, state_q == GRANT ? s_q : last_q);
    assign exit_d = !REQ[s_q] || cnt_q == CW'(BURST_LEN);
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            s_q     <= '0;
            en_q    <= 1'b1;
            last_q  <= 2'd3;
            cnt_q   <= '0;
        end else if (state_q == GRANT && !exit_d) begin
            cnt_q <= cnt_q + 1'b1;
        end else begin
            if (state_q == GRANT) last_q <= s_q;
`ifdef MUX4_ARB_GAP_EN
            if (state_q == GRANT || REQ == 4'b0) begin
                state_q <= state_q == GRANT ? GAP : IDLE;
`else
            if (REQ == 4'b0) begin
                state_q <= IDLE;
`endif
                gnt_q <= '0;
                en_q  <= 1'b1;
                cnt_q <= '0;
            end else begin
                state_q <= GRANT;
                gnt_q   <= 4'b1 << win_d;
                s_q     <= win_d;
                en_q    <= 1'b0;
                cnt_q   <= CW'(1);
            end
        end
    end
    assign GNT   = gnt_q;
    assign S     = s_q;
    assign EN    = en_q;
    assign VALID = ~en_q;
    mux4_dw #(.DW(DW)) u_mux (
        .a_i   (A),
        .b_i   (B),
        .c_i   (C),
        .d_i   (D),
        .sel_i (s_q),
        .en_n_i(en_q),
        .y_o   (Y)
    );
endmodule

// File: doc/mux4_rr_arbiter.md
Name: mux4_rr_arbiter

Overview:
Round-robin arbiter that shares one 4:1 DW-bit multiplexed channel between four requesters (channels 0..3 carry data A, B, C, D).
- Drives the mux select S and the active-low enable EN; EN=1 forces Y to zero.
- Holds each grant for at most BURST_LEN cycles.
- Sits between the requesting sources and the shared output bus Y.

Parameters:
- DW, 2, data width of A/B/C/D/Y.
- BURST_LEN, 4, max consecutive grant cycles per winner; legal range 1..15. Internal counter width is $clog2(BURST_LEN+1).

Ports:
- CLK  input  1  clock, rising edge.
- RST  input  1  asynchronous reset, active-high.
- REQ  input  4  request per channel; REQ[i] high = channel i wants the bus.
- A  input  DW  channel 0 data.
- B  input  DW  channel 1 data.
- C  input  DW  channel 2 data.
- D  input  DW  channel 3 data.
- GNT  output  4  one-hot grant, registered; all zero when no grant.
- S  output  2  registered mux select = index of granted channel.
- EN  output  1  registered active-low mux enable; 0 = Y driven by the selected channel.
- Y  output  DW  shared bus: EN ? 0 : selected input. Combinational from registered S/EN.
- VALID  output  1  equals ~EN.

Behaviour:
- Reset (async, immediate, independent of CLK): state=IDLE, GNT=0000, S=00, EN=1, Y=0, VALID=0, LAST=3, CNT=0. Reset mid-grant drops the bus in the same instant; no partial burst is resumed.
- Priority: search order starts at LAST+1 mod 4 and wraps. LAST is the last served channel, so it has lowest priority. Winner = first channel in that order with REQ high.
- States: IDLE, GRANT, GAP. GAP exists only with the optional feature.
- IDLE:
  - GNT=0, EN=1.
  - If REQ != 0 at an edge: next state GRANT, GNT=onehot(winner), S=winner, EN=0, CNT=1.
  - Latency REQ -> GNT is 1 cycle.
- GRANT (current channel cur):
  - Y carries the cur data.
  - Exit condition, sampled at an edge: REQ[cur]==0, or CNT==BURST_LEN.
  - On exit: LAST<=cur, then next state per the optional feature.
  - Otherwise: stay, CNT<=CNT+1.
- Re-grant: if cur is the only requester at exit, it is re-granted. That is a new burst with CNT=1; fairness is still enforced because LAST=cur.
- Handover without a gap: winner is computed with LAST=cur. If REQ (including cur) is 0 -> IDLE with EN=1 and GNT=0; else GRANT on the new winner with CNT=1.
- Simultaneous events: burst expiry and REQ[cur] drop on the same edge are treated as a single exit.
- BURST_LEN=1: every grant lasts exactly one cycle; four constant requesters rotate 0,1,2,3,0...
- REQ changes on non-winning channels during GRANT are ignored until exit.
- GNT, S and EN always change on the same edge. GNT is never multi-hot. EN=0 if and only if GNT != 0.

Optional Feature:
- Macro: MUX4_ARB_GAP_EN.
- Defined: every GRANT exit goes to GAP for exactly one cycle (GNT=0, EN=1, Y=0, S holds its value). At the next edge GAP arbitrates like IDLE: GRANT on the winner, or IDLE if REQ=0. Handover latency is 2 cycles.
- Undefined: no GAP state; handover is direct GRANT->GRANT in 1 cycle as described above.

Decomposition:
- Shared package mux4_arb_pkg:
  - state enum (IDLE, GRANT, GAP);
  - channel index typedef (2-bit);
  - constant NUM_CH=4;
  - function rr_pick(req, last) returning the winner index.
- One sub-module: mux4_dw, the parameterised 4:1 DW-bit mux with active-low EN, instantiated once for Y.
- Arbiter FSM and counter stay in mux4_rr_arbiter.

Test Plan:
- Reset: RST=1 mid-burst (GNT=0010) -> immediately GNT=0000, EN=1, Y=0, with no clock edge. After release with REQ=1111, the first grant is channel 0.
- Single requester: REQ=0100 for 10 cycles, C=2'b10, BURST_LEN=4 -> GNT=0100 one cycle after REQ. Y=10 continuously except at burst boundaries, where there is a one-cycle Y=0 only with MUX4_ARB_GAP_EN. Re-grants every 4 cycles.
- Rotation: REQ=1111, A=00, B=01, C=10, D=11, BURST_LEN=1, gap off -> S sequence 0,1,2,3,0 and Y sequence 00,01,10,11,00 on consecutive cycles.
- Early release: REQ=0011, channel 0 granted; drop REQ[0] after 2 grant cycles -> next edge GNT=0010, LAST=0, CNT restarts at 1.
- Burst cap: REQ=1001 held, BURST_LEN=4 -> channel 0 holds for exactly 4 cycles, then channel 3 for 4, then channel 0. Check GNT stays one-hot throughout.
- Idle return: REQ drops to 0000 during a grant -> next edge GNT=0000, EN=1, Y=0. Both builds end in IDLE; the gap build passes through GAP first.
